// File: rtl/spi_host_master_if.sv
// Purpose : byte-stream and SPI pin bundle for spi_host_master.
// Ports   : tx_* request stream in; rx_* received byte out; busy status;
//           spi_ss/spi_sclk/spi_mosi driven to the pins; spi_miso sampled from the pins.
interface spi_host_master_if;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] tx_data;
  logic       tx_last;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       busy;
  logic       spi_ss;
  logic       spi_sclk;
  logic       spi_mosi;
  logic       spi_miso;

  // View taken by the SPI master block itself.
  modport master (
    input  tx_valid, tx_data, tx_last, spi_miso,
    output tx_ready, rx_valid, rx_data, busy, spi_ss, spi_sclk, spi_mosi
  );

  // View taken by whatever feeds the stream and sits on the pins.
  modport slave (
    output tx_valid, tx_data, tx_last, spi_miso,
    input  tx_ready, rx_valid, rx_data, busy, spi_ss, spi_sclk, spi_mosi
  );
endinterface

// File: rtl/spi_host_master.sv
// Purpose     : single-lane SPI master, mode 0, MSB first; bytes from a valid/ready stream,
//               chip select held low across a burst until a byte flagged tx_last.
// Latency     : accept to rx_valid = CS_SETUP + 16*CLK_DIV + 1 cycles (next byte of a burst: 16*CLK_DIV + 1).
// Backpressure: tx_ready only in IDLE and in WAIT between burst bytes; WAIT stalls indefinitely with CS low.
// Ports       : clk, reset (sync, active high); bus = spi_host_master_if.master
//               (tx_valid/tx_ready/tx_data/tx_last, rx_valid/rx_data, busy, spi_ss/spi_sclk/spi_mosi/spi_miso).
module spi_host_master #(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_GAP   = 2
) (
  input  logic               clk,
  input  logic               reset,
  spi_host_master_if.master  bus
);

  if (CLK_DIV < 2) begin : g_bad_clk_div
    $error("spi_host_master: CLK_DIV must be >= 2");
  end
  if (CS_SETUP < 1) begin : g_bad_cs_setup
    $error("spi_host_master: CS_SETUP must be >= 1");
  end
  if (CS_HOLD < 1) begin : g_bad_cs_hold
    $error("spi_host_master: CS_HOLD must be >= 1");
  end
  if (CS_GAP < 1) begin : g_bad_cs_gap
    $error("spi_host_master: CS_GAP must be >= 1");
  end

  // Terminal counts for the shared phase counter.
  localparam logic [15:0] DIV_LAST   = 16'(CLK_DIV - 1);
  localparam logic [15:0] SETUP_LAST = 16'(CS_SETUP - 1);
  localparam logic [15:0] HOLD_LAST  = 16'(CS_HOLD - 1);
  localparam logic [15:0] GAP_LAST   = 16'(CS_GAP - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    WAIT,
    HOLD,
    GAP
  } state_t;

  state_t      state;
  logic [15:0] cnt;       // cycles spent in the current phase / half period
  logic [2:0]  bit_cnt;   // bits completed in the current byte
  logic [7:0]  tx_sh;     // MSB is the bit currently on spi_mosi
  logic [7:0]  rx_sh;
  logic        last_q;

  logic        tx_ready_q;
  logic        rx_valid_q;
  logic [7:0]  rx_data_q;
  logic        busy_q;
  logic        ss_q;
  logic        sclk_q;
  logic        mosi_q;

  logic        accept;
  assign accept = bus.tx_valid && tx_ready_q;

  assign bus.tx_ready = tx_ready_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.busy     = busy_q;
  assign bus.spi_ss   = ss_q;
  assign bus.spi_sclk = sclk_q;
  assign bus.spi_mosi = mosi_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_cnt    <= '0;
      tx_sh      <= '0;
      rx_sh      <= '0;
      last_q     <= 1'b0;
      tx_ready_q <= 1'b0;   // held low during reset, raised by the first IDLE cycle after it
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
      busy_q     <= 1'b0;
      ss_q       <= 1'b1;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            tx_sh      <= bus.tx_data;
            last_q     <= bus.tx_last;
            mosi_q     <= bus.tx_data[7];
            ss_q       <= 1'b0;
            tx_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            cnt        <= '0;
            state      <= SETUP;
          end else begin
            tx_ready_q <= 1'b1;
          end
        end

        SETUP: begin
          if (cnt == SETUP_LAST) begin
            cnt     <= '0;
            bit_cnt <= '0;
            state   <= SHIFT;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        SHIFT: begin
          if (cnt == DIV_LAST) begin
            cnt <= '0;
            if (!sclk_q) begin
              // Rising SCLK: capture MISO as it stands just before the edge.
              sclk_q <= 1'b1;
              rx_sh  <= {rx_sh[6:0], bus.spi_miso};
            end else begin
              sclk_q <= 1'b0;
              if (bit_cnt == 3'd7) begin
                rx_valid_q <= 1'b1;
                rx_data_q  <= rx_sh;
                if (last_q) begin
                  state <= HOLD;
                end else begin
                  tx_ready_q <= 1'b1;
                  state      <= WAIT;
                end
              end else begin
                bit_cnt <= bit_cnt + 3'd1;
                tx_sh   <= {tx_sh[6:0], 1'b0};
                mosi_q  <= tx_sh[6];
              end
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        WAIT: begin
          // Next burst byte goes straight into its low half; CS stays asserted.
          if (accept) begin
            tx_sh      <= bus.tx_data;
            last_q     <= bus.tx_last;
            mosi_q     <= bus.tx_data[7];
            tx_ready_q <= 1'b0;
            cnt        <= '0;
            bit_cnt    <= '0;
            state      <= SHIFT;
          end
        end

        HOLD: begin
          if (cnt == HOLD_LAST) begin
            cnt    <= '0;
            ss_q   <= 1'b1;
            mosi_q <= 1'b0;
            state  <= GAP;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        GAP: begin
          if (cnt == GAP_LAST) begin
            cnt        <= '0;
            tx_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            state      <= IDLE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/spi_host_master.md
# spi_host_master

Single-lane SPI master (mode 0, MSB first) that drives the chip's `dcs`/`dsck`/`io0` pins and samples `io1`: the initiator end of the serial link served by the FPGA-side `MyTopLevel` responder. It lives in the host-side/loopback test fabric and shifts bytes taken from a valid/ready stream. It returns each received byte as a one-cycle pulse and holds chip-select low across multi-byte bursts.

## Interface
Parameters:
- `CLK_DIV`, default 4: SCLK half-period in `clk` cycles; legal range is >= 2.
- `CS_SETUP`, default 2: cycles with `spi_ss` low before the first SCLK edge; legal range is >= 1.
- `CS_HOLD`, default 2: cycles with `spi_ss` low after the last SCLK falling edge of a burst; legal range is >= 1.
- `CS_GAP`, default 2: minimum cycles with `spi_ss` high between bursts; legal range is >= 1.

Ports:
- `clk`, in, 1: the single clock; every register is clocked on its rising edge.
- `reset`, in, 1: synchronous, active-high.
- `tx_valid`, in, 1: `tx_data`/`tx_last` are valid.
- `tx_ready`, out, 1: the block accepts a byte; a transfer happens when `tx_valid && tx_ready`.
- `tx_data`, in, 8: byte to transmit.
- `tx_last`, in, 1: this byte ends the burst; `spi_ss` is released after it.
- `rx_valid`, out, 1: one-cycle pulse; `rx_data` holds the byte received during the byte just finished.
- `rx_data`, out, 8: received byte, held until the next `rx_valid`.
- `busy`, out, 1: high whenever the state is not IDLE.
- `spi_ss`, out, 1: chip select, active low.
- `spi_sclk`, out, 1: serial clock, idle low.
- `spi_mosi`, out, 1: serial data out.
- `spi_miso`, in, 1: serial data in; sampled directly with no synchronizer.

## Operation
States: IDLE, SETUP, SHIFT, WAIT, HOLD, GAP. All outputs are registered.

- **IDLE**
  - `tx_ready`=1, `spi_ss`=1, `spi_sclk`=0, `spi_mosi`=0.
  - On accept: latch `tx_data` and `tx_last`, then go to SETUP.
- **SETUP**
  - `spi_ss`=0, `spi_mosi`=bit7.
  - Lasts CS_SETUP cycles, then go to SHIFT.
- **SHIFT**
  - 8 bits; each bit is a low half (CLK_DIV cycles, `spi_sclk`=0) followed by a high half (CLK_DIV cycles, `spi_sclk`=1).
  - On the edge that drives `spi_sclk` 0→1, `spi_miso` is shifted into the receive register at the LSB.
  - On the edge that drives `spi_sclk` 1→0 (bits 6..0), `spi_mosi` advances to the next bit.
  - `tx_ready`=0.
- **End of byte** (edge that ends the high half of bit 0):
  - `spi_sclk`←0, `rx_valid`←1, `rx_data`←receive register.
  - Next state is HOLD if the latched `tx_last`=1, otherwise WAIT.
- **WAIT**
  - `spi_ss`=0, `spi_sclk`=0, `spi_mosi` holds bit 0, `tx_ready`=1.
  - On accept: latch the new byte, drive `spi_mosi`←new bit7, and go directly to SHIFT with no setup.
  - With no accept, WAIT persists indefinitely with `spi_ss` low.
- **HOLD**: `spi_ss`=0 for CS_HOLD cycles, then `spi_ss`←1, `spi_mosi`←0, go to GAP.
- **GAP**: `spi_ss`=1 for CS_GAP cycles, then go to IDLE.
- **Accept rules**: `tx_data`/`tx_last` are sampled only on the accept cycle. `tx_valid` while `tx_ready`=0 is ignored.
- **Reset values** (on the edge where `reset`=1, including mid-transfer):
  - State IDLE, `spi_ss`=1, `spi_sclk`=0, `spi_mosi`=0, `rx_valid`=0, `rx_data`=0x00, `busy`=0.
  - `tx_ready`=0 while `reset` is high; it goes to 1 on the first edge with `reset`=0.
  - A partial byte is discarded and no `rx_valid` is produced.
- **Parameters**: an illegal value (e.g. CLK_DIV<2) stops elaboration with a `$error`.

## Timing
All figures below use the defaults, with the accept at cycle 0 from IDLE.
- **Setup**: `spi_ss`=0 from cycle 1; SETUP occupies cycles 1–2.
- **Bit 7**: low half cycles 3–6; high half cycles 7–10, with the first MISO sample at the edge starting cycle 7.
- **Bit 0**: high half cycles 63–66.
- **End of byte**: cycle 67 has `spi_sclk`=0 and `rx_valid`=1.
- **HOLD**: cycles 67–68.
- **GAP**: `spi_ss`=1 from cycle 69, GAP occupies cycles 69–70, and `tx_ready`=1 at cycle 71.
- **Chip-select low time**: CS_SETUP + 16·CLK_DIV + CS_HOLD = 68 cycles.
- **Accept to `rx_valid`**: CS_SETUP + 16·CLK_DIV + 1 cycles.
- **Burst**: if `tx_last`=0 and the next byte is accepted at cycle 67 (in WAIT), its low half starts at cycle 68. The byte-to-byte period is then 16·CLK_DIV + 1 cycles.
- **Back-to-back bursts**: the minimum `tx_valid` gap is CS_HOLD + CS_GAP + 1 cycles.

## Test plan
- **Single byte, loopback**: `spi_miso`=`spi_mosi`, send 0xA5 with `tx_last`=1 → exactly 8 SCLK rising edges, MOSI 1,0,1,0,0,1,0,1, `rx_valid` at cycle 67 with `rx_data`=0xA5, `spi_ss` low for exactly 68 cycles, `tx_ready` back at cycle 71.
- **Slave model**: a mode-0 model returns 0x3C while 0x00 is sent → `rx_data`=0x3C. MOSI must be stable for at least CLK_DIV cycles around every SCLK rising edge.
- **Burst**: send 0x01, 0x80, 0xFF with `tx_last` only on 0xFF → `spi_ss` never rises between bytes, three `rx_valid` pulses with a loopback echo of 0x01, 0x80, 0xFF, 24 SCLK edges.
- **Backpressure**: in WAIT, hold `tx_valid`=0 for 50 cycles → `spi_ss`=0, `spi_sclk`=0, no `rx_valid`. Then send 0x5A with `tx_last` → the burst completes normally.
- **Reset mid-byte**: assert `reset` for 1 cycle during bit 3 → next edge `spi_ss`=1, `spi_sclk`=0, no `rx_valid`, `tx_ready`=1 one cycle after release. A new byte then transfers correctly.
- **Ignored input**: toggle `tx_valid`/`tx_data` randomly during SHIFT → the transmitted byte equals the value latched at accept.
